// File: rtl/memory_controller.sv
// memory_controller: byte-serial arbiter/sequencer for the single 8-bit RAM/IO port.
// Shares the port between the instruction fetcher (IF) and the load/store buffer (LSB).
// Each accepted 1/2/4-byte request becomes a sequence of byte accesses. Read bytes are
// reassembled little-endian, and every completion is signalled by a one-cycle pulse.
//
// Ports:
//   Sys_clk, Sys_rst     clock, asynchronous active-high reset
//   Sys_rdy              global enable; low freezes state, forces mem_wr and pulses low
//   RoBMC_pre_judge      0 = misprediction flush (aborts fetches only)
//   IFMC_en/IFMC_addr    4-byte fetch request
//   MCIF_en/MCIF_data    fetch done pulse and instruction
//   LSBMC_*              LSB request: en, wr (1 = store), data_width, addr, store data
//   MCLSB_r_en/w_en      LSB read/write done pulses
//   MCLSB_data           LSB read data (zero-extended)
//   mem_din              RAM read byte, one cycle behind mem_a
//   mem_dout/mem_a       RAM write byte and address
//   mem_wr               RAM write strobe
//   io_buffer_full       stalls stores to IO space
module memory_controller #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [1:0]  IO_MASK    = 2'b11
) (
  input  logic                  Sys_clk,
  input  logic                  Sys_rst,
  input  logic                  Sys_rdy,
  input  logic                  RoBMC_pre_judge,
  input  logic                  IFMC_en,
  input  logic [ADDR_WIDTH-1:0] IFMC_addr,
  output logic                  MCIF_en,
  output logic [31:0]           MCIF_data,
  input  logic                  LSBMC_en,
  input  logic                  LSBMC_wr,
  input  logic [2:0]            LSBMC_data_width,
  input  logic [ADDR_WIDTH-1:0] LSBMC_addr,
  input  logic [31:0]           LSBMC_data,
  output logic                  MCLSB_r_en,
  output logic                  MCLSB_w_en,
  output logic [31:0]           MCLSB_data,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  typedef enum logic [1:0] {StIdle, StIfRd, StLsbRd, StLsbWr} state_e;

  state_e                state_q, state_d;
  logic [2:0]            k_q, k_d;
  logic [2:0]            n_q, n_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  prio_if_q, prio_if_d;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [7:0]            mem_dout_q, mem_dout_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  mcif_en_q, mcif_en_d;
  logic [31:0]           mcif_data_q, mcif_data_d;
  logic                  mclsb_r_en_q, mclsb_r_en_d;
  logic                  mclsb_w_en_q, mclsb_w_en_d;
  logic [31:0]           mclsb_data_q, mclsb_data_d;

  logic                  pulse_busy;
  logic                  if_req, lsb_req, grant_if, grant_lsb;
  logic [2:0]            k_inc;
  logic [2:0]            lsb_n;
  logic [ADDR_WIDTH-1:0] cur_addr, next_addr;
  logic                  io_stall, acc_io_stall;
  logic [7:0]            wr_byte;
  logic [1:0]            byte_idx;
  logic [31:0]           rdata_merge;

  // Requests seen while a done pulse is high are ignored; flushes block new fetches.
  assign pulse_busy = mcif_en_q | mclsb_r_en_q | mclsb_w_en_q;
  assign if_req     = IFMC_en & RoBMC_pre_judge & ~pulse_busy;
  assign lsb_req    = LSBMC_en & ~pulse_busy;
  // prio_if_q = 1 means IF wins the next contended arbitration.
  assign grant_if   = if_req & (~lsb_req | prio_if_q);
  assign grant_lsb  = lsb_req & ~grant_if;

  assign k_inc      = k_q + 3'd1;
  assign cur_addr   = addr_q + {{(ADDR_WIDTH-3){1'b0}}, k_q};
  assign next_addr  = addr_q + {{(ADDR_WIDTH-3){1'b0}}, k_inc};

  assign io_stall     = (cur_addr[17:16] == IO_MASK) && io_buffer_full;
  assign acc_io_stall = (LSBMC_addr[17:16] == IO_MASK) && io_buffer_full;

  always_comb begin
    unique case (LSBMC_data_width)
      3'd1:    lsb_n = 3'd1;
      3'd2:    lsb_n = 3'd2;
      default: lsb_n = 3'd4;
    endcase
  end

  always_comb begin
    unique case (k_q[1:0])
      2'd0: wr_byte = wdata_q[7:0];
      2'd1: wr_byte = wdata_q[15:8];
      2'd2: wr_byte = wdata_q[23:16];
      default: wr_byte = wdata_q[31:24];
    endcase
  end

  // The byte sampled at an edge belongs to the address issued two edges earlier (k-1).
  assign byte_idx = k_q[1:0] - 2'd1;
  always_comb begin
    rdata_merge = rdata_q;
    rdata_merge[{byte_idx, 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    n_d          = n_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    prio_if_d    = prio_if_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = 1'b0;
    mcif_en_d    = 1'b0;
    mcif_data_d  = mcif_data_q;
    mclsb_r_en_d = 1'b0;
    mclsb_w_en_d = 1'b0;
    mclsb_data_d = mclsb_data_q;

    if (Sys_rdy) begin
      unique case (state_q)
        StIdle: begin
          if (if_req && lsb_req) begin
            prio_if_d = ~prio_if_q;
          end
          if (grant_if) begin
            state_d = StIfRd;
            addr_d  = IFMC_addr;
            n_d     = 3'd4;
            k_d     = 3'd0;
            rdata_d = '0;
            mem_a_d = IFMC_addr;
          end else if (grant_lsb) begin
            addr_d  = LSBMC_addr;
            n_d     = lsb_n;
            wdata_d = LSBMC_data;
            rdata_d = '0;
            mem_a_d = LSBMC_addr;
            if (LSBMC_wr) begin
              state_d = StLsbWr;
              // Byte 0 goes out on the accept edge unless IO space is full.
              if (acc_io_stall) begin
                k_d = 3'd0;
              end else begin
                mem_dout_d = LSBMC_data[7:0];
                mem_wr_d   = 1'b1;
                k_d        = 3'd1;
              end
            end else begin
              state_d = StLsbRd;
              k_d     = 3'd0;
            end
          end
        end

        StIfRd, StLsbRd: begin
          if (state_q == StIfRd && !RoBMC_pre_judge) begin
            state_d = StIdle;
            k_d     = 3'd0;
            mem_a_d = '0;
          end else begin
            if (k_q != 3'd0) begin
              rdata_d = rdata_merge;
            end
            if (k_q == n_q) begin
              state_d = StIdle;
              k_d     = 3'd0;
              if (state_q == StIfRd) begin
                mcif_en_d   = 1'b1;
                mcif_data_d = rdata_merge;
              end else begin
                mclsb_r_en_d = 1'b1;
                mclsb_data_d = rdata_merge;
              end
            end else begin
              if (k_inc < n_q) begin
                mem_a_d = next_addr;
              end
              k_d = k_inc;
            end
          end
        end

        StLsbWr: begin
          if (k_q == n_q) begin
            state_d      = StIdle;
            k_d          = 3'd0;
            mclsb_w_en_d = 1'b1;
          end else if (!io_stall) begin
            mem_a_d    = cur_addr;
            mem_dout_d = wr_byte;
            mem_wr_d   = 1'b1;
            k_d        = k_inc;
          end
        end

        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      state_q      <= StIdle;
      k_q          <= '0;
      n_q          <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      prio_if_q    <= 1'b0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= 1'b0;
      mcif_en_q    <= 1'b0;
      mcif_data_q  <= '0;
      mclsb_r_en_q <= 1'b0;
      mclsb_w_en_q <= 1'b0;
      mclsb_data_q <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      n_q          <= n_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      prio_if_q    <= prio_if_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
      mcif_en_q    <= mcif_en_d;
      mcif_data_q  <= mcif_data_d;
      mclsb_r_en_q <= mclsb_r_en_d;
      mclsb_w_en_q <= mclsb_w_en_d;
      mclsb_data_q <= mclsb_data_d;
    end
  end

  assign mem_a      = mem_a_q;
  assign mem_dout   = mem_dout_q;
  assign mem_wr     = mem_wr_q;
  assign MCIF_en    = mcif_en_q;
  assign MCIF_data  = mcif_data_q;
  assign MCLSB_r_en = mclsb_r_en_q;
  assign MCLSB_w_en = mclsb_w_en_q;
  assign MCLSB_data = mclsb_data_q;

endmodule

// File: tb/tb_memory_controller.sv
// tb_memory_controller: directed bench for memory_controller with a small byte RAM model.
module tb_memory_controller;

  logic        Sys_clk;
  logic        Sys_rst;
  logic        Sys_rdy;
  logic        RoBMC_pre_judge;
  logic        IFMC_en;
  logic [31:0] IFMC_addr;
  logic        MCIF_en;
  logic [31:0] MCIF_data;
  logic        LSBMC_en;
  logic        LSBMC_wr;
  logic [2:0]  LSBMC_data_width;
  logic [31:0] LSBMC_addr;
  logic [31:0] LSBMC_data;
  logic        MCLSB_r_en;
  logic        MCLSB_w_en;
  logic [31:0] MCLSB_data;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  int unsigned n_checks;
  int unsigned n_fail;

  // RAM model: registered read, write on strobe, preload port used during reset.
  logic [7:0]  ram [0:65535];
  logic        pl_we;
  logic [15:0] pl_a;
  logic [7:0]  pl_d;

  memory_controller #(
    .ADDR_WIDTH (32),
    .IO_MASK    (2'b11)
  ) dut (
    .Sys_clk          (Sys_clk),
    .Sys_rst          (Sys_rst),
    .Sys_rdy          (Sys_rdy),
    .RoBMC_pre_judge  (RoBMC_pre_judge),
    .IFMC_en          (IFMC_en),
    .IFMC_addr        (IFMC_addr),
    .MCIF_en          (MCIF_en),
    .MCIF_data        (MCIF_data),
    .LSBMC_en         (LSBMC_en),
    .LSBMC_wr         (LSBMC_wr),
    .LSBMC_data_width (LSBMC_data_width),
    .LSBMC_addr       (LSBMC_addr),
    .LSBMC_data       (LSBMC_data),
    .MCLSB_r_en       (MCLSB_r_en),
    .MCLSB_w_en       (MCLSB_w_en),
    .MCLSB_data       (MCLSB_data),
    .mem_din          (mem_din),
    .mem_dout         (mem_dout),
    .mem_a            (mem_a),
    .mem_wr           (mem_wr),
    .io_buffer_full   (io_buffer_full)
  );

  initial Sys_clk = 1'b0;
  always #5 Sys_clk = ~Sys_clk;

  always @(posedge Sys_clk) begin
    if (pl_we) ram[pl_a] <= pl_d;
    else if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
    mem_din <= ram[mem_a[15:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled and inputs driven here.
  task automatic tick();
    @(posedge Sys_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pl_a  = a;
    pl_d  = d;
    pl_we = 1'b1;
    tick();
    pl_we = 1'b0;
  endtask

  task automatic lsb_req(input logic wr, input logic [2:0] w, input logic [31:0] a,
                         input logic [31:0] d);
    LSBMC_en         = 1'b1;
    LSBMC_wr         = wr;
    LSBMC_data_width = w;
    LSBMC_addr       = a;
    LSBMC_data       = d;
  endtask

  initial begin
    logic [31:0] wd;
    n_checks = 0;
    n_fail   = 0;
    Sys_rst = 1'b0; Sys_rdy = 1'b1; RoBMC_pre_judge = 1'b1;
    IFMC_en = 1'b0; IFMC_addr = '0;
    LSBMC_en = 1'b0; LSBMC_wr = 1'b0; LSBMC_data_width = 3'd0; LSBMC_addr = '0;
    LSBMC_data = '0; io_buffer_full = 1'b0;
    pl_we = 1'b0; pl_a = '0; pl_d = '0;

    #2 Sys_rst = 1'b1;
    #1;
    check("rst mem_a", mem_a, 32'h0);
    check("rst mem_dout", {24'h0, mem_dout}, 32'h0);
    check("rst mem_wr", {31'h0, mem_wr}, 32'h0);
    check("rst MCIF_en", {31'h0, MCIF_en}, 32'h0);
    check("rst MCIF_data", MCIF_data, 32'h0);
    check("rst MCLSB_r_en", {31'h0, MCLSB_r_en}, 32'h0);
    check("rst MCLSB_w_en", {31'h0, MCLSB_w_en}, 32'h0);
    check("rst MCLSB_data", MCLSB_data, 32'h0);

    preload(16'h0100, 8'h13);
    preload(16'h0101, 8'h05);
    preload(16'h0102, 8'hA0);
    preload(16'h0103, 8'h00);
    preload(16'h2001, 8'hFE);
    preload(16'h2002, 8'hFF);
    Sys_rst = 1'b0;
    tick();

    // Fetch 0x100: address steps, pulse 5 cycles after accept.
    IFMC_en = 1'b1; IFMC_addr = 32'h100;
    tick();
    IFMC_en = 1'b0;
    check("fetch a0", mem_a, 32'h100);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("fetch addr step", mem_a, 32'h100 + k);
    end
    tick();
    check("fetch no early pulse", {31'h0, MCIF_en}, 32'h0);
    tick();
    check("fetch pulse", {31'h0, MCIF_en}, 32'h1);
    check("fetch data", MCIF_data, 32'h00A00513);
    tick();
    check("fetch pulse width", {31'h0, MCIF_en}, 32'h0);
    check("fetch data hold", MCIF_data, 32'h00A00513);

    // lh at 0x2001: pulse 3 cycles after accept.
    lsb_req(1'b0, 3'd2, 32'h2001, 32'h0);
    tick();
    LSBMC_en = 1'b0;
    check("lh a0", mem_a, 32'h2001);
    tick();
    check("lh a1", mem_a, 32'h2002);
    tick();
    check("lh no early pulse", {31'h0, MCLSB_r_en}, 32'h0);
    tick();
    check("lh pulse", {31'h0, MCLSB_r_en}, 32'h1);
    check("lh data", MCLSB_data, 32'h0000FFFE);
    tick();
    check("lh pulse width", {31'h0, MCLSB_r_en}, 32'h0);

    // Contended fetch + sw: LSB first after reset, fetch follows after a bubble.
    IFMC_en = 1'b1; IFMC_addr = 32'h40;
    wd = 32'hDEADBEEF;
    lsb_req(1'b1, 3'd4, 32'h40, wd);
    tick();
    LSBMC_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) tick();
      check("sw mem_wr", {31'h0, mem_wr}, 32'h1);
      check("sw mem_a", mem_a, 32'h40 + k);
      check("sw byte", {24'h0, mem_dout}, (wd >> (8 * k)) & 32'hFF);
    end
    tick();
    check("sw wr drop", {31'h0, mem_wr}, 32'h0);
    check("sw w_en", {31'h0, MCLSB_w_en}, 32'h1);
    tick();
    check("sw w_en width", {31'h0, MCLSB_w_en}, 32'h0);
    tick();
    IFMC_en = 1'b0;
    check("fetch2 start", mem_a, 32'h40);
    check("fetch2 no wr", {31'h0, mem_wr}, 32'h0);
    ticks(4);
    check("fetch2 no early pulse", {31'h0, MCIF_en}, 32'h0);
    tick();
    check("fetch2 pulse", {31'h0, MCIF_en}, 32'h1);
    check("fetch2 data", MCIF_data, 32'hDEADBEEF);
    tick();

    // Second contended pair: IF wins this time.
    IFMC_en = 1'b1; IFMC_addr = 32'h100;
    lsb_req(1'b1, 3'd1, 32'h44, 32'h55);
    tick();
    IFMC_en = 1'b0;
    check("pair2 IF first", mem_a, 32'h100);
    check("pair2 no wr", {31'h0, mem_wr}, 32'h0);
    ticks(5);
    check("pair2 fetch pulse", {31'h0, MCIF_en}, 32'h1);
    check("pair2 fetch data", MCIF_data, 32'h00A00513);
    ticks(2);
    LSBMC_en = 1'b0;
    check("pair2 sb wr", {31'h0, mem_wr}, 32'h1);
    check("pair2 sb addr", mem_a, 32'h44);
    check("pair2 sb byte", {24'h0, mem_dout}, 32'h55);
    tick();
    check("pair2 sb w_en", {31'h0, MCLSB_w_en}, 32'h1);
    check("pair2 sb wr drop", {31'h0, mem_wr}, 32'h0);
    tick();

    // IO store stalled for 3 cycles by io_buffer_full.
    io_buffer_full = 1'b1;
    lsb_req(1'b1, 3'd1, 32'h30000, 32'h41);
    tick();
    LSBMC_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) tick();
      check("io stall wr", {31'h0, mem_wr}, 32'h0);
    end
    io_buffer_full = 1'b0;
    tick();
    check("io wr", {31'h0, mem_wr}, 32'h1);
    check("io addr", mem_a, 32'h30000);
    check("io byte", {24'h0, mem_dout}, 32'h41);
    tick();
    check("io w_en", {31'h0, MCLSB_w_en}, 32'h1);
    tick();

    // Flush during fetch after byte 1 is sampled; pending lb is accepted next.
    IFMC_en = 1'b1; IFMC_addr = 32'h100;
    tick();
    IFMC_en = 1'b0;
    lsb_req(1'b0, 3'd1, 32'h2001, 32'h0);
    ticks(3);
    RoBMC_pre_judge = 1'b0;
    tick();
    RoBMC_pre_judge = 1'b1;
    check("flush no pulse", {31'h0, MCIF_en}, 32'h0);
    check("flush mem_a", mem_a, 32'h0);
    tick();
    LSBMC_en = 1'b0;
    check("flush lb accepted", mem_a, 32'h2001);
    check("flush still no pulse", {31'h0, MCIF_en}, 32'h0);
    ticks(2);
    check("flush lb pulse", {31'h0, MCLSB_r_en}, 32'h1);
    check("flush lb data", MCLSB_data, 32'h000000FE);
    tick();

    // Fetch request during a flush in IDLE is not accepted on that edge.
    RoBMC_pre_judge = 1'b0;
    IFMC_en = 1'b1; IFMC_addr = 32'h100;
    tick();
    check("idle flush blocks fetch", mem_a, 32'h2001);
    RoBMC_pre_judge = 1'b1;
    tick();
    IFMC_en = 1'b0;
    check("fetch after flush", mem_a, 32'h100);
    ticks(5);
    check("fetch after flush pulse", {31'h0, MCIF_en}, 32'h1);
    tick();

    // Flush during sw: store is not torn.
    RoBMC_pre_judge = 1'b0;
    wd = 32'h11223344;
    lsb_req(1'b1, 3'd4, 32'h48, wd);
    tick();
    LSBMC_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) tick();
      check("flush sw wr", {31'h0, mem_wr}, 32'h1);
      check("flush sw byte", {24'h0, mem_dout}, (wd >> (8 * k)) & 32'hFF);
    end
    tick();
    check("flush sw w_en", {31'h0, MCLSB_w_en}, 32'h1);
    RoBMC_pre_judge = 1'b1;
    tick();

    // Asynchronous reset mid-store drops mem_wr without a clock edge.
    lsb_req(1'b1, 3'd4, 32'h4C, 32'hCAFEF00D);
    tick();
    LSBMC_en = 1'b0;
    tick();
    check("pre-rst wr", {31'h0, mem_wr}, 32'h1);
    Sys_rst = 1'b1;
    #1;
    check("async rst wr", {31'h0, mem_wr}, 32'h0);
    check("async rst mem_a", mem_a, 32'h0);
    tick();
    Sys_rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_controller.md
# memory_controller

Byte-serial arbiter and sequencer for the single 8-bit RAM/IO port, shared between the instruction fetcher (IF) and the load/store buffer (LSB). Accepts one 1/2/4-byte request at a time, splits it into byte accesses, reassembles read data little-endian and returns a one-cycle completion pulse. Stalls IO writes on `io_buffer_full` and aborts in-flight instruction fetches on misprediction.

## Interface
- `ADDR_WIDTH`, 32, RAM address width
- `IO_MASK`, 2'b11, value of `addr[17:16]` that selects IO space
- `Sys_clk` in 1: clock
- `Sys_rst` in 1: reset, asynchronous, active-high
- `Sys_rdy` in 1: global enable; low freezes all state
- `RoBMC_pre_judge` in 1: 0 means misprediction flush this cycle
- `IFMC_en` in 1, `IFMC_addr` in 32: fetch request, 4 bytes
- `MCIF_en` out 1, `MCIF_data` out 32: fetch done pulse and instruction
- `LSBMC_en` in 1, `LSBMC_wr` in 1 (0 read, 1 write), `LSBMC_data_width` in 3, `LSBMC_addr` in 32, `LSBMC_data` in 32
- `MCLSB_r_en` out 1, `MCLSB_w_en` out 1, `MCLSB_data` out 32: LSB done pulses, read data (zero-extended, raw)
- `mem_din` in 8: RAM read byte
- `mem_dout` out 8, `mem_a` out 32, `mem_wr` out 1: RAM write byte, address, write strobe
- `io_buffer_full` in 1: IO write buffer full

## Operation
- States: IDLE, IF_RD, LSB_RD, LSB_WR. Byte counter `k`, length `N` = width (1, 2, 4; any other value is treated as 4).
- IDLE accepts at a rising edge when a request is present and no done pulse is currently high. Accept latches addr, N, write data and requester.
- Arbitration on simultaneous IF and LSB requests: last-served loses (alternating priority); after reset LSB wins.
- Read: byte k address `A+k` is driven after edge E_k (E_0 = accept edge); `mem_din` is sampled at E_{k+2} into bits `[8k+7:8k]`, with unused upper bytes 0. After E_{N+1}: done pulse with data, state IDLE.
- Write: after E_k, `mem_a=A+k`, `mem_dout=data[8k+7:8k]`, `mem_wr=1`, for k=0..N-1. After E_N: `mem_wr=0`, `MCLSB_w_en=1`, state IDLE.
- IO stall: a write byte whose `addr[17:16]==IO_MASK` is not issued while `io_buffer_full=1`. Hold `k` with `mem_wr=0` and retry each cycle.
- Flush (`RoBMC_pre_judge=0` at an edge):
  - IF_RD goes to IDLE with no `MCIF_en` pulse, and `mem_a` returns to 0.
  - In IDLE, IF requests are not accepted on that edge.
  - LSB_RD and LSB_WR always run to completion; the LSB discards the stale read pulse itself. Stores are never torn.
- Done pulses are exactly one cycle wide; data outputs hold their value until the next completion.
- `Sys_rdy=0`: no state change, `mem_wr` forced 0, pulses held low.

## Timing
- Reset values: state IDLE, k=0, priority=LSB. `mem_a`, `mem_dout`, `mem_wr`, `MCIF_en`, `MCIF_data`, `MCLSB_r_en`, `MCLSB_w_en`, `MCLSB_data` are all 0.
- All outputs are registered.
- Fetch latency: accept edge to pulse-visible is 5 cycles. LSB read is N+1 cycles. LSB write is N cycles plus IO stall cycles.
- Minimum gap: one IDLE cycle (the pulse cycle) between consecutive transactions.
- Requesters must drop `*_en` in the pulse cycle. The controller ignores requests in that cycle regardless.
- Address arithmetic is 32-bit wrap-around (`0xFFFFFFFF+1 = 0`).

## Test plan
- Fetch: `IFMC_addr=0x100`, RAM `[0x100..0x103]=13 05 A0 00`. Response: `mem_a` steps 0x100..0x103, then `MCIF_en` pulses once 5 cycles after accept with `MCIF_data=0x00A00513`.
- LSB `lh` read at 0x2001 with bytes `FE FF`. Response: `MCLSB_r_en` pulse after 3 cycles, `MCLSB_data=0x0000FFFE`.
- Simultaneous fetch and `sw 0xDEADBEEF` to 0x40:
  - LSB is served first: `mem_wr` high for 4 cycles with bytes EF BE AD DE, then `MCLSB_w_en`.
  - The fetch starts after one bubble cycle.
  - A second simultaneous pair is then served IF first.
- IO `sb 0x41` to 0x30000 with `io_buffer_full` high for 3 cycles. Response: `mem_wr` stays 0 for those 3 cycles, the write is issued the cycle after full drops, and `MCLSB_w_en` follows.
- Flush during fetch: `RoBMC_pre_judge=0` at the edge after byte 1 is sampled. Response: no `MCIF_en`, IDLE next cycle, and a pending LSB read is accepted next.
- Flush during `sw`: the store completes all 4 bytes and `MCLSB_w_en` still pulses. Async `Sys_rst` mid-write drops `mem_wr` to 0 immediately.
